prefetcher_data_multi_stream: RTL and testbench

Per-stream prefetch data buffer: the next generation of the single-queue prefetch data store, parametrised in stream count, depth, block size and promise width. Each stream owns a circular queue of block entries tracking outstanding DRAM reads, returned data and master "promises", i.e. demanded reads pending service. It sits between the prefetch engine / AXI AR path and the AXI R path, one instance per prefetcher. Over the single-queue version it adds per-stream isolation, saturating promise counters, block-aligned matching, extended error reporting and optional flush.

---
 rtl/prefetcher_data_multi_stream.sv | 235 +++++++++++++++++++++++
 tb/tb_prefetcher_data_multi_stream.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prefetcher_data_multi_stream.sv
// Per-stream prefetch data buffer; opcode 5 flush exists only with PREFETCHER_DATA_FLUSH_EN defined.
// Latency: ops commit at the next edge, resp*/errorCode registered one cycle later, status outputs combinational from state.
// Backpressure: none; callers gate readDataPromise on dataReady and allocations on almostFull.
module prefetcher_data_multi_stream #(
    parameter int NUM_STREAMS          = 4,
    parameter int LOG_QUEUE_SIZE       = 3,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int ADDR_BITS            = 64,
    parameter int PROMISE_WIDTH        = 3,
    localparam int STREAM_BITS = $clog2(NUM_STREAMS),
    localparam int BLOCK_BITS  = 8 << LOG_BLOCK_DATA_BYTES,
    localparam int CNT_BITS    = LOG_QUEUE_SIZE + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [2:0]                      reqOpcode,
    input  logic [STREAM_BITS-1:0]          reqStream,
    input  logic [ADDR_BITS-1:0]            reqAddr,
    input  logic [BLOCK_BITS-1:0]           reqData,
    input  logic [LOG_QUEUE_SIZE-1:0]       crs_almostFullSpacer,
    output logic                            respValid,
    output logic [BLOCK_BITS-1:0]           respData,
    output logic [ADDR_BITS-1:0]            respAddr,
    output logic [STREAM_BITS-1:0]          respStream,
    output logic [NUM_STREAMS-1:0]          dataReady,
    output logic [NUM_STREAMS-1:0]          almostFull,
    output logic [NUM_STREAMS*CNT_BITS-1:0] outstandingReqCnt,
    output logic [2:0]                      errorCode
);
    localparam int QW    = LOG_QUEUE_SIZE;
    localparam int DEPTH = 1 << LOG_QUEUE_SIZE;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PREF    = 3'd1;
    localparam logic [2:0] OP_MASTER  = 3'd2;
    localparam logic [2:0] OP_SLAVE   = 3'd3;
    localparam logic [2:0] OP_PROMISE = 3'd4;
`ifdef PREFETCHER_DATA_FLUSH_EN
    localparam logic [2:0] OP_FLUSH   = 3'd5;
`endif

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_INVALID   = 3'd1;
    localparam logic [2:0] ERR_FULL      = 3'd2;
    localparam logic [2:0] ERR_NOT_READY = 3'd3;
    localparam logic [2:0] ERR_DATA_MISS = 3'd4;
    localparam logic [2:0] ERR_PROM_SAT  = 3'd5;
    localparam logic [2:0] ERR_DUP_PREF  = 3'd6;

    localparam logic [PROMISE_WIDTH-1:0] PROM_MAX = '1;

    logic [DEPTH-1:0]         valid_q [NUM_STREAMS];
    logic [DEPTH-1:0]         dvld_q  [NUM_STREAMS];
    logic [DEPTH-1:0]         outs_q  [NUM_STREAMS];
    logic [PROMISE_WIDTH-1:0] prom_q  [NUM_STREAMS][DEPTH];
    logic [ADDR_BITS-1:0]     addr_q  [NUM_STREAMS][DEPTH];
    logic [BLOCK_BITS-1:0]    data_q  [NUM_STREAMS][DEPTH];
    logic [QW-1:0]            head_q  [NUM_STREAMS];
    logic [QW-1:0]            tail_q  [NUM_STREAMS];
    logic [CNT_BITS-1:0]      cnt_q   [NUM_STREAMS];

    logic                     resp_vld_q;
    logic [BLOCK_BITS-1:0]    resp_dat_q;
    logic [ADDR_BITS-1:0]     resp_addr_q;
    logic [STREAM_BITS-1:0]   resp_strm_q;
    logic [2:0]               err_q;
    logic [2:0]               err_d;

    logic [ADDR_BITS-1:0]     blk_addr;
    logic [QW-1:0]            req_head;
    logic [QW-1:0]            scan_idx;
    logic [QW-1:0]            hit_idx;
    logic [QW-1:0]            srv_idx;
    logic [QW-1:0]            hn;
    logic                     hit;
    logic                     full;
    logic                     nx_rdy;
    logic [CNT_BITS-1:0]      ocnt;
    logic [NUM_STREAMS-1:0]   head_rdy;

    assign blk_addr = reqAddr & ~ADDR_BITS'((1 << LOG_BLOCK_DATA_BYTES) - 1);

    // Per-stream status; head+1 only counts when the head carries no promise.
    always_comb begin
        head_rdy          = '0;
        dataReady         = '0;
        almostFull        = '0;
        outstandingReqCnt = '0;
        hn                = '0;
        nx_rdy            = 1'b0;
        ocnt              = '0;
        for (int s = 0; s < NUM_STREAMS; s++) begin
            hn          = head_q[s] + QW'(1);
            head_rdy[s] = valid_q[s][head_q[s]] & dvld_q[s][head_q[s]] & (prom_q[s][head_q[s]] != '0);
            nx_rdy      = valid_q[s][hn] & dvld_q[s][hn] & (prom_q[s][hn] != '0);
            dataReady[s] = head_rdy[s] |
                           ((cnt_q[s] >= CNT_BITS'(2)) & (prom_q[s][head_q[s]] == '0) & nx_rdy);
            almostFull[s] = ({1'b0, cnt_q[s]} + (CNT_BITS+1)'(crs_almostFullSpacer))
                            >= (CNT_BITS+1)'(DEPTH);
            ocnt = '0;
            for (int e = 0; e < DEPTH; e++) begin
                ocnt = ocnt + CNT_BITS'(valid_q[s][e] & outs_q[s][e]);
            end
            outstandingReqCnt[s*CNT_BITS +: CNT_BITS] = ocnt;
        end
    end

    // Scan from head so the oldest matching entry wins.
    always_comb begin
        req_head = head_q[reqStream];
        hit      = 1'b0;
        hit_idx  = req_head;
        scan_idx = req_head;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = req_head + QW'(k);
            if (!hit && valid_q[reqStream][scan_idx] && (addr_q[reqStream][scan_idx] == blk_addr)) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    assign full    = (cnt_q[reqStream] == CNT_BITS'(DEPTH));
    assign srv_idx = head_rdy[reqStream] ? req_head : req_head + QW'(1);

    always_comb begin
        err_d = ERR_NONE;
        case (reqOpcode)
            OP_NOP:     err_d = ERR_NONE;
            OP_PREF: begin
                if (hit)       err_d = ERR_DUP_PREF;
                else if (full) err_d = ERR_FULL;
            end
            OP_MASTER: begin
                if (hit) begin
                    if (prom_q[reqStream][hit_idx] == PROM_MAX) err_d = ERR_PROM_SAT;
                end else if (full) begin
                    err_d = ERR_FULL;
                end
            end
            OP_SLAVE: begin
                if (!(hit && outs_q[reqStream][hit_idx])) err_d = ERR_DATA_MISS;
            end
            OP_PROMISE: begin
                if (!dataReady[reqStream]) err_d = ERR_NOT_READY;
            end
`ifdef PREFETCHER_DATA_FLUSH_EN
            OP_FLUSH:   err_d = ERR_NONE;
`endif
            default:    err_d = ERR_INVALID;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                valid_q[s] <= '0;
                dvld_q[s]  <= '0;
                outs_q[s]  <= '0;
                head_q[s]  <= '0;
                tail_q[s]  <= '0;
                cnt_q[s]   <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    prom_q[s][e] <= '0;
                    addr_q[s][e] <= '0;
                end
            end
            resp_vld_q  <= 1'b0;
            resp_dat_q  <= '0;
            resp_addr_q <= '0;
            resp_strm_q <= '0;
            err_q       <= ERR_NONE;
        end else begin
            err_q      <= err_d;
            resp_vld_q <= 1'b0;
            if (err_d == ERR_NONE) begin
                case (reqOpcode)
                    OP_PREF, OP_MASTER: begin
                        if (reqOpcode == OP_MASTER && hit) begin
                            prom_q[reqStream][hit_idx] <= prom_q[reqStream][hit_idx] + PROMISE_WIDTH'(1);
                        end else begin
                            valid_q[reqStream][tail_q[reqStream]] <= 1'b1;
                            dvld_q[reqStream][tail_q[reqStream]]  <= 1'b0;
                            outs_q[reqStream][tail_q[reqStream]]  <= 1'b1;
                            prom_q[reqStream][tail_q[reqStream]]  <=
                                (reqOpcode == OP_MASTER) ? PROMISE_WIDTH'(1) : '0;
                            addr_q[reqStream][tail_q[reqStream]]  <= blk_addr;
                            tail_q[reqStream] <= tail_q[reqStream] + QW'(1);
                            cnt_q[reqStream]  <= cnt_q[reqStream] + CNT_BITS'(1);
                        end
                    end
                    OP_SLAVE: begin
                        dvld_q[reqStream][hit_idx] <= 1'b1;
                        outs_q[reqStream][hit_idx] <= 1'b0;
                    end
                    OP_PROMISE: begin
                        // A non-ready head is dead weight in front of the served entry.
                        if (!head_rdy[reqStream]) begin
                            valid_q[reqStream][req_head] <= 1'b0;
                            head_q[reqStream] <= req_head + QW'(1);
                            cnt_q[reqStream]  <= cnt_q[reqStream] - CNT_BITS'(1);
                        end
                        prom_q[reqStream][srv_idx] <= prom_q[reqStream][srv_idx] - PROMISE_WIDTH'(1);
                        resp_vld_q  <= 1'b1;
                        resp_dat_q  <= data_q[reqStream][srv_idx];
                        resp_addr_q <= addr_q[reqStream][srv_idx];
                        resp_strm_q <= reqStream;
                    end
`ifdef PREFETCHER_DATA_FLUSH_EN
                    OP_FLUSH: begin
                        valid_q[reqStream] <= '0;
                        head_q[reqStream]  <= '0;
                        tail_q[reqStream]  <= '0;
                        cnt_q[reqStream]   <= '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reqOpcode == OP_SLAVE && err_d == ERR_NONE) begin
            data_q[reqStream][hit_idx] <= reqData;
        end
    end

    assign respValid  = resp_vld_q;
    assign respData   = resp_dat_q;
    assign respAddr   = resp_addr_q;
    assign respStream = resp_strm_q;
    assign errorCode  = err_q;

endmodule

// File: tb/tb_prefetcher_data_multi_stream.sv
// Scoreboarded bench for prefetcher_data_multi_stream; flush checks follow PREFETCHER_DATA_FLUSH_EN.
`timescale 1ns/1ps
module tb_prefetcher_data_multi_stream;
    localparam int NS = 4, CW = 4, BB = 512, AW = 64, SB = 2;
    localparam logic [2:0] OP_NOP = 3'd0, OP_PREF = 3'd1, OP_MASTER = 3'd2, OP_SLAVE = 3'd3;
    localparam logic [2:0] OP_PROMISE = 3'd4, OP_FLUSH = 3'd5;
    localparam int K_ERR = 0, K_DRDY = 1, K_AFULL = 2, K_OCNT = 3, K_RVLD = 4, K_RZERO = 5;

    typedef struct { int due; int kind; int idx; logic [63:0] exp; } chk_t;
    typedef struct { int due; logic [BB-1:0] dat; logic [AW-1:0] addr; logic [SB-1:0] strm; } rsp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        reqOpcode;
    logic [SB-1:0]     reqStream;
    logic [AW-1:0]     reqAddr;
    logic [BB-1:0]     reqData;
    logic [2:0]        spacer;
    logic              respValid;
    logic [BB-1:0]     respData;
    logic [AW-1:0]     respAddr;
    logic [SB-1:0]     respStream;
    logic [NS-1:0]     dataReady;
    logic [NS-1:0]     almostFull;
    logic [NS*CW-1:0]  outstandingReqCnt;
    logic [2:0]        errorCode;

    chk_t chk_q[$];
    rsp_t rsp_q[$];
    chk_t cur;
    rsp_t rc;
    logic [63:0] got;
    int checks = 0, errors = 0, cyc = 0;
    logic done = 1'b0, drained = 1'b0;
    logic [BB-1:0] D1, D2, D3;

    prefetcher_data_multi_stream dut (
        .clk(clk), .reset(reset), .reqOpcode(reqOpcode), .reqStream(reqStream),
        .reqAddr(reqAddr), .reqData(reqData), .crs_almostFullSpacer(spacer),
        .respValid(respValid), .respData(respData), .respAddr(respAddr), .respStream(respStream),
        .dataReady(dataReady), .almostFull(almostFull), .outstandingReqCnt(outstandingReqCnt),
        .errorCode(errorCode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_ERR:   return "errorCode";
            K_DRDY:  return "dataReady";
            K_AFULL: return "almostFull";
            K_OCNT:  return "outstandingReqCnt";
            K_RVLD:  return "respValid";
            default: return "resp_reset_zero";
        endcase
    endfunction

    // Drive one op just after the edge; its errorCode is due the cycle after it commits.
    task automatic step(input logic [2:0] op, input int st, input logic [63:0] a,
                        input logic [BB-1:0] d, input int err);
        @(posedge clk);
        #1;
        reqOpcode = op;
        reqStream = SB'(st);
        reqAddr   = a;
        reqData   = d;
        chk_q.push_back('{cyc + 1, K_ERR, 0, 64'(err)});
    endtask

    task automatic exp_st(input int kind, input int idx, input logic [63:0] v);
        chk_q.push_back('{cyc + 1, kind, idx, v});
    endtask

    task automatic exp_rsp(input logic [BB-1:0] d, input logic [63:0] a, input int st);
        rsp_q.push_back('{cyc + 1, d, a, SB'(st)});
    endtask

    always @(negedge clk) begin
        while (chk_q.size() != 0 && chk_q[0].due <= cyc) begin
            cur = chk_q.pop_front();
            case (cur.kind)
                K_ERR:   got = 64'(errorCode);
                K_DRDY:  got = 64'(dataReady);
                K_AFULL: got = 64'(almostFull);
                K_OCNT:  got = (cur.idx < 0) ? 64'(outstandingReqCnt)
                                             : 64'(outstandingReqCnt[cur.idx*CW +: CW]);
                K_RVLD:  got = 64'(respValid);
                default: got = 64'((respData == '0) && (respAddr == '0) && (respStream == '0));
            endcase
            checks++;
            if (got !== cur.exp) begin
                errors++;
                $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", kname(cur.kind), cur.idx, cyc, got, cur.exp);
            end
        end
        if (respValid) begin
            checks++;
            if (rsp_q.size() == 0 || rsp_q[0].due != cyc) begin
                errors++;
                $display("FAIL resp_unexpected cycle %0d: got respValid 1 addr %0h expected no response", cyc, respAddr);
            end else begin
                rc = rsp_q.pop_front();
                checks++;
                if (respAddr !== rc.addr) begin
                    errors++;
                    $display("FAIL resp_addr cycle %0d: got %0h expected %0h", cyc, respAddr, rc.addr);
                end
                checks++;
                if (respStream !== rc.strm) begin
                    errors++;
                    $display("FAIL resp_stream cycle %0d: got %0d expected %0d", cyc, respStream, rc.strm);
                end
                checks++;
                if (respData !== rc.dat) begin
                    errors++;
                    $display("FAIL resp_data cycle %0d: got %0h expected %0h", cyc, respData[31:0], rc.dat[31:0]);
                end
            end
        end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            rc = rsp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL resp_missing cycle %0d: got respValid 0 expected 1 addr %0h", cyc, rc.addr);
        end
        if (done && !drained) begin
            drained = 1'b1;
            checks++;
            if (chk_q.size() != 0 || rsp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d checks and %0d responses pending expected 0", chk_q.size(), rsp_q.size());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        D1 = {16{32'h1111_a001}};
        D2 = {16{32'h2222_b002}};
        D3 = {16{32'h3333_c003}};
        reset = 1'b1; reqOpcode = OP_NOP; reqStream = '0; reqAddr = '0; reqData = '0; spacer = 3'd2;
        exp_st(K_ERR, 0, 0); exp_st(K_DRDY, 0, 0); exp_st(K_AFULL, 0, 0);
        exp_st(K_OCNT, -1, 0); exp_st(K_RVLD, 0, 0); exp_st(K_RZERO, 0, 1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Stream 1: demand, fill (unaligned address), serve, then starve
        step(OP_MASTER, 1, 64'h1040, '0, 0);  exp_st(K_OCNT, 1, 1); exp_st(K_DRDY, 0, 0);
        step(OP_SLAVE, 1, 64'h105A, D1, 0);   exp_st(K_DRDY, 0, 4'b0010); exp_st(K_OCNT, 1, 0);
        step(OP_PROMISE, 1, 64'h0, '0, 0);    exp_rsp(D1, 64'h1040, 1); exp_st(K_DRDY, 0, 0);
        step(OP_PROMISE, 1, 64'h0, '0, 3);

        // Stream 0: fill to depth, almostFull from 6th alloc with spacer 2
        for (int i = 0; i < 8; i++) begin
            step(OP_PREF, 0, 64'(i * 64), '0, 0);
            exp_st(K_AFULL, 0, (i >= 5) ? 64'd1 : 64'd0);
        end
        exp_st(K_OCNT, 0, 8);
        step(OP_PREF, 0, 64'h200, '0, 2);
        step(OP_PREF, 0, 64'h47, '0, 6);
        step(OP_MASTER, 0, 64'h40, '0, 0);
        step(OP_SLAVE, 0, 64'h40, D2, 0);     exp_st(K_DRDY, 0, 4'b0001); exp_st(K_OCNT, 0, 7);
        step(OP_PROMISE, 0, 64'h0, '0, 0);    exp_rsp(D2, 64'h40, 0);
        exp_st(K_DRDY, 0, 0); exp_st(K_OCNT, 0, 6); exp_st(K_AFULL, 0, 4'b0001);
        step(OP_SLAVE, 0, 64'h0, D1, 4);
        step(OP_PREF, 0, 64'h200, '0, 0);     exp_st(K_OCNT, 0, 7);
        step(OP_PREF, 0, 64'h240, '0, 2);
        step(OP_SLAVE, 0, 64'h80, D1, 0);     exp_st(K_OCNT, 0, 6); exp_st(K_DRDY, 0, 0);

        // Stream 2: promise saturation at 7
        for (int i = 0; i < 8; i++) step(OP_MASTER, 2, 64'h80, '0, (i == 7) ? 5 : 0);
        exp_st(K_OCNT, 2, 1);
        step(OP_SLAVE, 2, 64'h80, D3, 0);     exp_st(K_DRDY, 0, 4'b0100);
        for (int i = 0; i < 7; i++) begin
            step(OP_PROMISE, 2, 64'h0, '0, 0);
            exp_rsp(D3, 64'h80, 2);
        end
        exp_st(K_DRDY, 0, 0);
        step(OP_PROMISE, 2, 64'h0, '0, 3);
        step(OP_SLAVE, 2, 64'h80, D3, 4);

        // Stream isolation and invalid opcodes
        step(OP_PREF, 3, 64'h3000, '0, 0);    exp_st(K_OCNT, 3, 1);
        step(OP_SLAVE, 2, 64'h3000, D1, 4);   exp_st(K_OCNT, 3, 1);
        step(3'd6, 1, 64'h0, '0, 1);
        step(3'd7, 2, 64'h0, '0, 1);
`ifdef PREFETCHER_DATA_FLUSH_EN
        step(OP_FLUSH, 0, 64'h0, '0, 0);
        exp_st(K_OCNT, 0, 0); exp_st(K_AFULL, 0, 0); exp_st(K_DRDY, 0, 0); exp_st(K_OCNT, 3, 1);
        step(OP_PREF, 0, 64'h40, '0, 0);      exp_st(K_OCNT, 0, 1);
`else
        step(OP_FLUSH, 0, 64'h0, '0, 1);
        exp_st(K_OCNT, 0, 6); exp_st(K_AFULL, 0, 4'b0001);
`endif

        // Reset mid-run discards outstanding reads
        step(OP_NOP, 0, 64'h0, '0, 0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        exp_st(K_OCNT, -1, 0); exp_st(K_DRDY, 0, 0); exp_st(K_ERR, 0, 0); exp_st(K_AFULL, 0, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        step(OP_SLAVE, 3, 64'h3000, D1, 4);
        step(OP_PROMISE, 2, 64'h0, '0, 3);
        step(OP_NOP, 0, 64'h0, '0, 0);        exp_st(K_OCNT, -1, 0);

        repeat (4) @(negedge clk);
        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
